// File: rtl/board_matrix_scanner_if.sv
// ---------------------------------------------------------------------------
// board_matrix_scanner_if
//
// Frame hand-off bundle between the game core (master) and the LED matrix
// scanner (slave).
//
// Handshake: frameValid is a single-cycle strobe. frameIn is captured on the
// rising edge where frameValid is high. The transfer is always accepted, so
// frameValid does not wait for frameReady. If a frame is already pending, the
// newer frame replaces it. frameReady only reports that the pending buffer is
// empty. frameSwap pulses for one cycle when the pending frame moves into the
// display buffer.
//
// Signals:
//   frameIn    [63:0] master->slave  board image, row r = frameIn[8r+7:8r]
//   frameValid        master->slave  capture strobe for frameIn
//   frameReady        slave->master  pending buffer empty
//   frameSwap         slave->master  one-cycle pulse on pending->display move
// ---------------------------------------------------------------------------
interface board_matrix_scanner_if;
    logic [63:0] frameIn;
    logic        frameValid;
    logic        frameReady;
    logic        frameSwap;

    modport master (
        output frameIn,
        output frameValid,
        input  frameReady,
        input  frameSwap
    );

    modport slave (
        input  frameIn,
        input  frameValid,
        output frameReady,
        output frameSwap
    );
endinterface

// File: rtl/board_matrix_scanner.sv
// ---------------------------------------------------------------------------
// board_matrix_scanner
//
// Double-buffered 8x8 LED matrix row scanner. A board image arrives through
// the frame interface into a pending buffer. The display buffer is scanned
// one row at a time. Each row is lit for DWELL_CYCLES clocks, and then every
// row is dark for GHOST_CYCLES clocks. The pending buffer is copied into the
// display buffer only at the end of row 7, so one scan pass always shows a
// single frame.
//
// Optional feature macro: SCAN_BRIGHTNESS_EN. When it is defined, the block
// adds the brightness[2:0] input. The row is then driven only for the first
// (brightness+1)*DWELL_CYCLES/8 clocks of each dwell. The brightness value is
// sampled when the block enters SHOW.
//
// Parameters:
//   DWELL_CYCLES  clocks each row is lit (must be >= 2)
//   GHOST_CYCLES  dark clocks between rows (must be >= 1)
//
// Ports:
//   clk          system clock, rising edge
//   rstBtn       asynchronous active-high reset
//   frameBus     frame hand-off (slave side): frameIn, frameValid,
//                frameReady, frameSwap
//   blank        forces rowSel/colData to 0 from the next clock; scan
//                timing keeps running
//   brightness   [2:0] dwell duty setting (only with SCAN_BRIGHTNESS_EN)
//   rowSel       [7:0] one-hot active-high row enable (registered)
//   colData      [7:0] column drive for the selected row (registered)
//   scanRow      [2:0] index of the current or next row
//   dbgState     [1:0] FSM state: 0 IDLE, 1 SHOW, 2 GHOST
// ---------------------------------------------------------------------------
module board_matrix_scanner #(
    parameter int DWELL_CYCLES = 1000,
    parameter int GHOST_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rstBtn,
    board_matrix_scanner_if.slave        frameBus,
    input  logic                         blank,
`ifdef SCAN_BRIGHTNESS_EN
    input  logic [2:0]                   brightness,
`endif
    output logic [7:0]                   rowSel,
    output logic [7:0]                   colData,
    output logic [2:0]                   scanRow,
    output logic [1:0]                   dbgState
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > GHOST_CYCLES) ? DWELL_CYCLES : GHOST_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    // The counter counts down to 0, so a state lasts (load value + 1) clocks.
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GHOST_LOAD = CW'(GHOST_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        GHOST = 2'd2
    } scanState_t;

    scanState_t    state;
    scanState_t    stateNext;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNext;
    logic [2:0]    scanRowNext;
    logic          doSwap;
    logic          enterShow;

    logic [63:0]   pending;
    logic          pendFull;
    logic [63:0]   display;

    logic [7:0]    rowSelNext;
    logic [7:0]    colDataNext;
    logic          rowLit;

`ifdef SCAN_BRIGHTNESS_EN
    logic [2:0]    brightReg;
    int            elapsed;
    int            litLimit;
`endif

    assign dbgState = state;

    // -----------------------------------------------------------------------
    // FSM state register plus the scan datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rstBtn) begin
        if (rstBtn) begin
            state   <= IDLE;
            cnt     <= '0;
            scanRow <= 3'd0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            scanRow <= scanRowNext;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Every state entry reloads the shared down-counter.
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        scanRowNext = scanRow;
        doSwap      = 1'b0;
        enterShow   = 1'b0;

        case (state)
            IDLE: begin
                // The first frame since reset is shown at once. No pass is
                // in progress yet, so nothing can be torn.
                if (pendFull) begin
                    doSwap      = 1'b1;
                    enterShow   = 1'b1;
                    stateNext   = SHOW;
                    scanRowNext = 3'd0;
                    cntNext     = DWELL_LOAD;
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    stateNext = GHOST;
                    cntNext   = GHOST_LOAD;
                    // Swap only at the end of a full pass.
                    if (scanRow == 3'd7 && pendFull) begin
                        doSwap = 1'b1;
                    end
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            GHOST: begin
                if (cnt == '0) begin
                    stateNext   = SHOW;
                    enterShow   = 1'b1;
                    scanRowNext = scanRow + 3'd1;
                    cntNext     = DWELL_LOAD;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Frame buffers. On an edge that both swaps and receives a new frame, the
    // old pending frame goes to display, the new one is held, and pendFull
    // stays set.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rstBtn) begin
        if (rstBtn) begin
            pending             <= 64'd0;
            pendFull            <= 1'b0;
            display             <= 64'd0;
            frameBus.frameReady <= 1'b1;
            frameBus.frameSwap  <= 1'b0;
        end else begin
            frameBus.frameSwap <= doSwap;
            if (doSwap) begin
                display <= pending;
            end
            if (frameBus.frameValid) begin
                pending  <= frameBus.frameIn;
                pendFull <= 1'b1;
            end else if (doSwap) begin
                pendFull <= 1'b0;
            end
            // Matches the value pendFull takes on this same edge.
            frameBus.frameReady <= ~(frameBus.frameValid | (pendFull & ~doSwap));
        end
    end

    // -----------------------------------------------------------------------
    // Brightness gate within the dwell
    // -----------------------------------------------------------------------
`ifdef SCAN_BRIGHTNESS_EN
    always_ff @(posedge clk or posedge rstBtn) begin
        if (rstBtn) begin
            brightReg <= 3'd7;
        end else if (enterShow) begin
            brightReg <= brightness;
        end
    end

    // elapsed is the number of dwell clocks already spent in this SHOW.
    always_comb begin
        elapsed  = (DWELL_CYCLES - 1) - int'(cnt);
        litLimit = ((int'(brightReg) + 1) * DWELL_CYCLES) / 8;
        rowLit   = (state == SHOW) && (elapsed < litLimit);
    end
`else
    always_comb begin
        rowLit = (state == SHOW);
    end
`endif

    // -----------------------------------------------------------------------
    // Output register. The outputs follow the FSM state with one clock of
    // delay. As a result, rowSel first rises two clocks after the first
    // frameValid, and blank takes effect one clock after it is asserted.
    // -----------------------------------------------------------------------
    always_comb begin
        rowSelNext  = 8'd0;
        colDataNext = 8'd0;
        if (rowLit && !blank) begin
            rowSelNext  = 8'd1 << scanRow;
            colDataNext = display[{scanRow, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or posedge rstBtn) begin
        if (rstBtn) begin
            rowSel  <= 8'd0;
            colData <= 8'd0;
        end else begin
            rowSel  <= rowSelNext;
            colData <= colDataNext;
        end
    end

endmodule

// File: tb/tb_board_matrix_scanner.sv
// ---------------------------------------------------------------------------
// tb_board_matrix_scanner
//
// Directed bench for board_matrix_scanner with DWELL_CYCLES=4 and
// GHOST_CYCLES=1. Edge e=0 is the edge that captures the first frame. After
// edge e, a row is lit when (e-2)%5 < 4, and that row is ((e-2)/5)%8. Swaps
// happen at e=1 (leaving IDLE) and at every e that is a multiple of 40
// (end of row 7), provided a frame is pending.
// ---------------------------------------------------------------------------
module tb_board_matrix_scanner;

    localparam int DWELL = 4;
    localparam int GHOST = 1;

    logic        clk = 1'b0;
    logic        rstBtn;
    logic        blank;
    logic [7:0]  rowSel;
    logic [7:0]  colData;
    logic [2:0]  scanRow;
    logic [1:0]  dbgState;
`ifdef SCAN_BRIGHTNESS_EN
    logic [2:0]  brightness;
`endif

    board_matrix_scanner_if bus ();

    int checks = 0;
    int errors = 0;

    // Reference state for expected values
    logic [63:0] dispM;
    logic [63:0] pendM;
    logic        pendFullM;

    always #5 clk = ~clk;

    board_matrix_scanner #(
        .DWELL_CYCLES (DWELL),
        .GHOST_CYCLES (GHOST)
    ) dut (
        .clk        (clk),
        .rstBtn     (rstBtn),
        .frameBus   (bus),
        .blank      (blank),
`ifdef SCAN_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .rowSel     (rowSel),
        .colData    (colData),
        .scanRow    (scanRow),
        .dbgState   (dbgState)
    );

    // ----------------------------------------------------------------- driver
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstBtn         = 1'b1;
        blank          = 1'b0;
        bus.frameValid = 1'b0;
        bus.frameIn    = 64'd0;
        tick();
        tick();
        rstBtn = 1'b0;
        tick();
        dispM     = 64'd0;
        pendM     = 64'd0;
        pendFullM = 1'b0;
    endtask

    // Edge e=0: capture the first frame after reset.
    task automatic strobeFirst(input logic [63:0] f);
        bus.frameIn    = f;
        bus.frameValid = 1'b1;
        tick();
        bus.frameValid = 1'b0;
        pendM     = f;
        pendFullM = 1'b1;
    endtask

    // ------------------------------------------------------ expected values
    function automatic logic [7:0] expRowSel(input int e);
        int p;
        p = e - 2;
        if (p < 0) return 8'h00;
        if ((p % 5) < 4) return 8'h01 << ((p / 5) % 8);
        return 8'h00;
    endfunction

    function automatic logic [7:0] expColData(input int e, input logic [7:0] r);
        int row;
        row = ((e - 2) / 5) % 8;
        if (r == 8'h00) return 8'h00;
        return dispM[8*row +: 8];
    endfunction

    // Updates the reference buffers for edge e. The output is the expected
    // frameSwap after that edge.
    task automatic modelEdge(input int e, input logic v, input logic [63:0] f,
                             output logic expSw);
        expSw = ((e == 1) || (e % 40 == 0)) && pendFullM;
        if (expSw) dispM = pendM;
        if (v) begin
            pendM     = f;
            pendFullM = 1'b1;
        end else if (expSw) begin
            pendFullM = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        doReset();
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (rowSel !== 8'h00 || colData !== 8'h00 || bus.frameReady !== 1'b1 ||
                dbgState !== 2'd0 || bus.frameSwap !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got rowSel=%h colData=%h ready=%b state=%0d swap=%b exp 00 00 1 0 0",
                         i, rowSel, colData, bus.frameReady, dbgState, bus.frameSwap);
            end
            tick();
        end
    endtask

    task automatic test_diagonal();
        logic [7:0] expR, expC;
        logic       expSw;
        doReset();
        strobeFirst(64'h8040201008040201);
        checks++;
        if (bus.frameReady !== 1'b0) begin
            errors++;
            $display("FAIL diag_ready_fall got %b exp 0", bus.frameReady);
        end
        for (int e = 1; e <= 44; e++) begin
            tick();
            expR = expRowSel(e);
            expC = expColData(e, expR);
            modelEdge(e, 1'b0, 64'd0, expSw);
            checks++;
            if (rowSel !== expR || colData !== expC || bus.frameSwap !== expSw ||
                bus.frameReady !== !pendFullM) begin
                errors++;
                $display("FAIL diag e=%0d got rowSel=%h colData=%h swap=%b ready=%b exp %h %h %b %b",
                         e, rowSel, colData, bus.frameSwap, bus.frameReady,
                         expR, expC, expSw, !pendFullM);
            end
        end
    endtask

    task automatic test_blank();
        logic [7:0] expR, expC;
        logic       expSw;
        doReset();
        strobeFirst(64'h8040201008040201);
        for (int e = 1; e <= 20; e++) begin
            blank = (e >= 10 && e <= 14);
            tick();
            expR = (e >= 10 && e <= 14) ? 8'h00 : expRowSel(e);
            expC = expColData(e, expR);
            modelEdge(e, 1'b0, 64'd0, expSw);
            checks++;
            if (rowSel !== expR || colData !== expC) begin
                errors++;
                $display("FAIL blank e=%0d got rowSel=%h colData=%h exp %h %h",
                         e, rowSel, colData, expR, expC);
            end
        end
        blank = 1'b0;
    endtask

    task automatic test_swap_midscan();
        logic [7:0]  expR, expC;
        logic        expSw, v;
        logic [63:0] f;
        doReset();
        strobeFirst({64{1'b1}});
        for (int e = 1; e <= 56; e++) begin
            v = (e == 18);
            f = 64'd0;
            bus.frameIn    = f;
            bus.frameValid = v;
            tick();
            bus.frameValid = 1'b0;
            expR = expRowSel(e);
            expC = expColData(e, expR);
            modelEdge(e, v, f, expSw);
            checks++;
            if (rowSel !== expR || colData !== expC || bus.frameSwap !== expSw ||
                bus.frameReady !== !pendFullM) begin
                errors++;
                $display("FAIL swap_mid e=%0d got rowSel=%h colData=%h swap=%b ready=%b exp %h %h %b %b",
                         e, rowSel, colData, bus.frameSwap, bus.frameReady,
                         expR, expC, expSw, !pendFullM);
            end
        end
    endtask

    task automatic test_latest_wins();
        logic [7:0]  expR, expC;
        logic        expSw, v;
        logic [63:0] f;
        doReset();
        strobeFirst(64'h0123456789ABCDEF);
        for (int e = 1; e <= 52; e++) begin
            v = (e == 10) || (e == 25);
            f = (e == 10) ? 64'hC3C3C3C3C3C3C3C3 : 64'h5A3C0FA5F01E7781;
            bus.frameIn    = f;
            bus.frameValid = v;
            tick();
            bus.frameValid = 1'b0;
            expR = expRowSel(e);
            expC = expColData(e, expR);
            modelEdge(e, v, f, expSw);
            checks++;
            if (rowSel !== expR || colData !== expC || bus.frameSwap !== expSw ||
                bus.frameReady !== !pendFullM) begin
                errors++;
                $display("FAIL latest_wins e=%0d got rowSel=%h colData=%h swap=%b ready=%b exp %h %h %b %b",
                         e, rowSel, colData, bus.frameSwap, bus.frameReady,
                         expR, expC, expSw, !pendFullM);
            end
        end
    endtask

    task automatic test_swap_edge_strobe();
        logic [7:0]  expR, expC;
        logic        expSw, v;
        logic [63:0] f;
        doReset();
        strobeFirst({64{1'b1}});
        for (int e = 1; e <= 92; e++) begin
            v = (e == 20) || (e == 40);
            f = (e == 20) ? 64'h00FF00FF00FF00FF : 64'h1122334455667788;
            bus.frameIn    = f;
            bus.frameValid = v;
            tick();
            bus.frameValid = 1'b0;
            expR = expRowSel(e);
            expC = expColData(e, expR);
            modelEdge(e, v, f, expSw);
            checks++;
            if (rowSel !== expR || colData !== expC || bus.frameSwap !== expSw ||
                bus.frameReady !== !pendFullM) begin
                errors++;
                $display("FAIL swap_edge e=%0d got rowSel=%h colData=%h swap=%b ready=%b exp %h %h %b %b",
                         e, rowSel, colData, bus.frameSwap, bus.frameReady,
                         expR, expC, expSw, !pendFullM);
            end
        end
    endtask

    task automatic test_reset_midscan();
        doReset();
        strobeFirst({64{1'b1}});
        for (int e = 1; e <= 23; e++) tick();
        // Row 4 is lit here, and a second frame is still pending.
        bus.frameIn    = 64'h0F0F0F0F0F0F0F0F;
        bus.frameValid = 1'b1;
        checks++;
        if (rowSel !== 8'h10 || colData !== 8'hFF) begin
            errors++;
            $display("FAIL rst_mid_before got rowSel=%h colData=%h exp 10 ff", rowSel, colData);
        end
        tick();
        bus.frameValid = 1'b0;
        #1 rstBtn = 1'b1;
        #1;
        checks++;
        if (rowSel !== 8'h00 || colData !== 8'h00 || bus.frameReady !== 1'b1 ||
            dbgState !== 2'd0 || scanRow !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_async got rowSel=%h colData=%h ready=%b state=%0d row=%0d exp 00 00 1 0 0",
                     rowSel, colData, bus.frameReady, dbgState, scanRow);
        end
        #2 rstBtn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (rowSel !== 8'h00 || dbgState !== 2'd0 || bus.frameReady !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_discard cyc=%0d got rowSel=%h state=%0d ready=%b exp 00 0 1",
                         i, rowSel, dbgState, bus.frameReady);
            end
        end
    endtask

`ifdef SCAN_BRIGHTNESS_EN
    task automatic test_brightness();
        int litCount;
        brightness = 3'd1;
        doReset();
        strobeFirst({64{1'b1}});
        tick();
        litCount = 0;
        for (int e = 2; e <= 6; e++) begin
            tick();
            if (rowSel != 8'h00) litCount++;
        end
        checks++;
        if (litCount !== 1) begin
            errors++;
            $display("FAIL brightness_1 lit clocks got %0d exp 1", litCount);
        end
        brightness = 3'd7;
    endtask
`endif

    initial begin
`ifdef SCAN_BRIGHTNESS_EN
        brightness = 3'd7;
`endif
        test_reset();
        test_diagonal();
        test_blank();
        test_swap_midscan();
        test_latest_wins();
        test_swap_edge_strobe();
        test_reset_midscan();
`ifdef SCAN_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
